// File: rtl/iquant_pkg.sv
// Shared MPEG-2 inverse-quantiser constants, coefficient type and saturation helper.
package iquant_pkg;

  localparam int COEF_W     = 12;
  localparam int SAT_MIN    = -2048;
  localparam int SAT_MAX    = 2047;
  localparam int BLOCK_SIZE = 64;
  localparam int IQ_LATENCY = 3;
  localparam int IDX_W      = $clog2(BLOCK_SIZE);
  localparam int WGT_W      = 8;
  localparam int QS_W       = 7;
  localparam int DCM_W      = 5;
  localparam int PROD_W     = 28;
  localparam int QSHIFT     = 5;

  typedef logic signed [COEF_W-1:0] coef_t;

  typedef enum logic [1:0] {
    CLS_INTRA_DC,
    CLS_INTRA_AC,
    CLS_NON_INTRA
  } coef_cls_e;

  function automatic coef_t sat_coef(input logic signed [PROD_W-1:0] v);
    if (v > PROD_W'(SAT_MAX))
      return COEF_W'(SAT_MAX);
    else if (v < PROD_W'(SAT_MIN))
      return COEF_W'(SAT_MIN);
    else
      return v[COEF_W-1:0];
  endfunction

endpackage

// File: rtl/iquant_qmat.sv
// 64x8 quantiser weight matrix: one write port, one registered read port (read-before-write).
module iquant_qmat
  import iquant_pkg::*;
(
  input  logic             clk,
  input  logic             clk_en,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [WGT_W-1:0] wr_data,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [WGT_W-1:0] rd_data
);

  logic [WGT_W-1:0] mem [BLOCK_SIZE];

  always_ff @(posedge clk) begin
    if (clk_en) begin
      if (wr_en)
        mem[wr_addr] <= wr_data;
      if (rd_en)
        rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/iquant.sv
// MPEG-2 inverse quantiser: 3-stage pipeline (weight fetch, scale/saturate, mismatch control).
// Define IQUANT_MISMATCH_EN to enable parity-based mismatch control on the last coefficient.
module iquant
  import iquant_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clk_en,
  input  logic signed [COEF_W-1:0] coef_level,
  input  logic                     coef_valid,
  input  logic                     intra,
  input  logic [QS_W-1:0]          quantiser_scale,
  input  logic [DCM_W-1:0]         intra_dc_mult,
  input  logic                     qmat_wr,
  input  logic [IDX_W-1:0]         qmat_addr,
  input  logic [WGT_W-1:0]         qmat_data,
  output logic signed [COEF_W-1:0] iquant_level,
  output logic                     iquant_valid
);

  localparam int QF2_W = COEF_W + 2;

  logic [IDX_W-1:0] idx;
  logic             at_dc;
  logic             blk_intra;
  logic [QS_W-1:0]  blk_qs;
  logic [DCM_W-1:0] blk_dcm;
  logic             cur_intra;
  logic [QS_W-1:0]  cur_qs;
  logic [DCM_W-1:0] cur_dcm;
  coef_cls_e        cur_cls;

  logic             s1_vld;
  coef_t            s1_qf;
  coef_cls_e        s1_cls;
  logic [QS_W-1:0]  s1_qs;
  logic [DCM_W-1:0] s1_dcm;
  logic [WGT_W-1:0] s1_w;

  logic signed [QF2_W-1:0]  qf2;
  logic signed [PROD_W-1:0] ac_prod;
  logic signed [PROD_W-1:0] ac_rnd;
  logic signed [PROD_W-1:0] dc_prod;
  logic signed [PROD_W-1:0] res;

  logic             s2_vld;
  coef_t            s2_sat;
  coef_t            out_level;

`ifdef IQUANT_MISMATCH_EN
  logic             s1_last;
  logic             s2_last;
  logic             par;
`endif

  iquant_qmat u_qmat (
    .clk     (clk),
    .clk_en  (clk_en),
    .wr_en   (qmat_wr),
    .wr_addr (qmat_addr),
    .wr_data (qmat_data),
    .rd_en   (coef_valid),
    .rd_addr (idx),
    .rd_data (s1_w)
  );

  // Block parameters are taken live at index 0 and from the held copy afterwards,
  // so a new block can follow the previous one without a bubble.
  always_comb begin
    at_dc     = (idx == '0);
    cur_intra = at_dc ? intra : blk_intra;
    cur_qs    = at_dc ? quantiser_scale : blk_qs;
    cur_dcm   = at_dc ? intra_dc_mult : blk_dcm;
    if (!cur_intra)
      cur_cls = CLS_NON_INTRA;
    else if (at_dc)
      cur_cls = CLS_INTRA_DC;
    else
      cur_cls = CLS_INTRA_AC;
  end

  always_comb begin
    qf2 = {s1_qf[COEF_W-1], s1_qf, 1'b0};
    if (s1_cls == CLS_NON_INTRA && s1_qf != '0)
      qf2 = s1_qf[COEF_W-1] ? qf2 - QF2_W'(1) : qf2 + QF2_W'(1);
    ac_prod = PROD_W'(qf2) * PROD_W'(signed'({1'b0, s1_w})) * PROD_W'(signed'({1'b0, s1_qs}));
    dc_prod = PROD_W'(s1_qf) * PROD_W'(signed'({1'b0, s1_dcm}));
    // Bias negatives before the arithmetic shift so division truncates toward zero.
    ac_rnd  = ac_prod + (ac_prod[PROD_W-1] ? PROD_W'((1 << QSHIFT) - 1) : PROD_W'(0));
    res     = (s1_cls == CLS_INTRA_DC) ? dc_prod : (ac_rnd >>> QSHIFT);
  end

  always_comb begin
    out_level = s2_sat;
`ifdef IQUANT_MISMATCH_EN
    if (s2_last && !(par ^ s2_sat[0]))
      out_level[0] = ~s2_sat[0];
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      idx          <= '0;
      s1_vld       <= 1'b0;
      s2_vld       <= 1'b0;
      iquant_valid <= 1'b0;
      iquant_level <= '0;
`ifdef IQUANT_MISMATCH_EN
      par          <= 1'b0;
`endif
    end else if (clk_en) begin
      s1_vld       <= coef_valid;
      s2_vld       <= s1_vld;
      iquant_valid <= s2_vld;
      if (coef_valid)
        idx <= idx + IDX_W'(1);
      if (s2_vld)
        iquant_level <= out_level;
`ifdef IQUANT_MISMATCH_EN
      if (s2_vld)
        par <= s2_last ? 1'b0 : (par ^ s2_sat[0]);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (clk_en) begin
      if (coef_valid) begin
        if (at_dc) begin
          blk_intra <= intra;
          blk_qs    <= quantiser_scale;
          blk_dcm   <= intra_dc_mult;
        end
        s1_qf  <= coef_level;
        s1_cls <= cur_cls;
        s1_qs  <= cur_qs;
        s1_dcm <= cur_dcm;
`ifdef IQUANT_MISMATCH_EN
        s1_last <= (idx == IDX_W'(BLOCK_SIZE - 1));
`endif
      end
      if (s1_vld) begin
        s2_sat <= sat_coef(res);
`ifdef IQUANT_MISMATCH_EN
        s2_last <= s1_last;
`endif
      end
    end
  end

endmodule
